bp_port_scheduler: RTL and testbench

Shares the branch predictor's single PC port between front-end lookups and back-end training updates. Resolved branches from two branch units, which may arrive in the same cycle, are queued in a small in-order FIFO. Each cycle the block grants the predictor to either one fetch lookup or one queued update. Lookups have priority, but an age-based starvation guard and a FIFO-full override guarantee that updates drain.

---
 rtl/bp_port_scheduler.sv | 143 ++++++++++++++
 tb/tb_bp_port_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_port_scheduler.sv
// Arbitrates the branch predictor's single PC port between fetch lookups and
// queued training updates from two branch units, with starvation and full-FIFO overrides.
module bp_port_scheduler #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,

  input  logic                       lookup_valid_in,
  input  logic [31:0]                lookup_pc_in,
  output logic                       lookup_ready_out,
  output logic                       pred_valid_out,
  output logic                       pred_taken_out,

  input  logic                       res0_valid_in,
  input  logic [31:0]                res0_pc_in,
  input  logic                       res0_taken_in,
  input  logic                       res1_valid_in,
  input  logic [31:0]                res1_pc_in,
  input  logic                       res1_taken_in,
  output logic                       res_ready_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,

  output logic [31:0]                bp_pc_out,
  output logic                       bp_update_valid_out,
  output logic                       bp_correct_branch_out,
  input  logic                       bp_taken_in
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ROOM_C  = CW'(DEPTH - 2);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_LOOKUP,
    GRANT_UPDATE
  } grant_e;

  logic [32:0]   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] tail1;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          pred_valid_q, pred_valid_d;

  grant_e        grant;
  logic          push0, push1, pop;
  logic [32:0]   head_entry;

  assign head_entry = mem_q[head_q];

  // Only registered count feeds the ready, so a same-cycle pop never widens the window.
  assign res_ready_out = rst_n_in && (count_q <= ROOM_C);
  assign push0         = res_ready_out && res0_valid_in;
  assign push1         = res_ready_out && res1_valid_in;
  assign tail1         = tail_q + PW'(push0);

  always_comb begin
    grant = GRANT_IDLE;
    if (!rst_n_in) begin
      grant = GRANT_IDLE;
    end else if ((count_q != '0) &&
                 (!lookup_valid_in || (starve_q >= LIMIT_C) || (count_q == DEPTH_C))) begin
      grant = GRANT_UPDATE;
    end else if (lookup_valid_in) begin
      grant = GRANT_LOOKUP;
    end
  end

  assign pop = (grant == GRANT_UPDATE);

  always_comb begin
    bp_pc_out             = '0;
    bp_update_valid_out   = 1'b0;
    bp_correct_branch_out = 1'b0;
    lookup_ready_out      = 1'b0;
    case (grant)
      GRANT_UPDATE: begin
        bp_pc_out             = head_entry[32:1];
        bp_correct_branch_out = head_entry[0];
        bp_update_valid_out   = 1'b1;
      end
      GRANT_LOOKUP: begin
        bp_pc_out        = lookup_pc_in;
        lookup_ready_out = 1'b1;
      end
      default: begin
        bp_pc_out = '0;
      end
    endcase
  end

  always_comb begin
    head_d       = head_q + PW'(pop);
    tail_d       = tail_q + PW'(push0) + PW'(push1);
    count_d      = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    pred_valid_d = (grant == GRANT_LOOKUP);
    starve_d     = starve_q;
    if (pop || (count_q == '0)) begin
      starve_d = '0;
    end else if (starve_q != LIMIT_C) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      pred_valid_q <= pred_valid_d;
    end
  end

  // Storage needs no reset: stale slots are unreachable once the pointers clear.
  always_ff @(posedge clk_in) begin
    if (push0) begin
      mem_q[tail_q] <= {res0_pc_in, res0_taken_in};
    end
    if (push1) begin
      mem_q[tail1] <= {res1_pc_in, res1_taken_in};
    end
  end

  assign count_out      = count_q;
  assign pred_valid_out = pred_valid_q;
  assign pred_taken_out = pred_valid_q && bp_taken_in;

endmodule

// File: tb/tb_bp_port_scheduler.sv
// Scoreboard bench for bp_port_scheduler: stimulus queues expected predictor
// updates and predictions, an independent monitor pops and compares them.
module tb_bp_port_scheduler;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        lookup_valid_in = 1'b0;
  logic [31:0] lookup_pc_in = '0;
  logic        lookup_ready_out;
  logic        pred_valid_out;
  logic        pred_taken_out;
  logic        res0_valid_in = 1'b0;
  logic [31:0] res0_pc_in = '0;
  logic        res0_taken_in = 1'b0;
  logic        res1_valid_in = 1'b0;
  logic [31:0] res1_pc_in = '0;
  logic        res1_taken_in = 1'b0;
  logic        res_ready_out;
  logic [2:0]  count_out;
  logic [31:0] bp_pc_out;
  logic        bp_update_valid_out;
  logic        bp_correct_branch_out;
  logic        bp_taken_in;

  logic        bpTakenModel = 1'b0;
  logic        bpForce = 1'b0;

  int          checks = 0;
  int          failures = 0;
  logic [32:0] expUpd[$];
  logic        expPred[$];

  bp_port_scheduler #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_in                (clk_in),
    .rst_n_in              (rst_n_in),
    .lookup_valid_in       (lookup_valid_in),
    .lookup_pc_in          (lookup_pc_in),
    .lookup_ready_out      (lookup_ready_out),
    .pred_valid_out        (pred_valid_out),
    .pred_taken_out        (pred_taken_out),
    .res0_valid_in         (res0_valid_in),
    .res0_pc_in            (res0_pc_in),
    .res0_taken_in         (res0_taken_in),
    .res1_valid_in         (res1_valid_in),
    .res1_pc_in            (res1_pc_in),
    .res1_taken_in         (res1_taken_in),
    .res_ready_out         (res_ready_out),
    .count_out             (count_out),
    .bp_pc_out             (bp_pc_out),
    .bp_update_valid_out   (bp_update_valid_out),
    .bp_correct_branch_out (bp_correct_branch_out),
    .bp_taken_in           (bp_taken_in)
  );

  always #5 clk_in = ~clk_in;

  // Predictor model: predicts PC bit 4, returned one cycle after the PC is presented.
  always @(posedge clk_in) bpTakenModel <= bp_pc_out[4];
  assign bp_taken_in = bpTakenModel | bpForce;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [31:0] lpc,
                               input logic r0v, input logic [31:0] r0pc, input logic r0t,
                               input logic r1v, input logic [31:0] r1pc, input logic r1t);
    @(posedge clk_in);
    #1;
    lookup_valid_in = lv;
    lookup_pc_in    = lpc;
    res0_valid_in   = r0v;
    res0_pc_in      = r0pc;
    res0_taken_in   = r0t;
    res1_valid_in   = r1v;
    res1_pc_in      = r1pc;
    res1_taken_in   = r1t;
    @(negedge clk_in);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic checkCycle(input string tag, input logic lr, input int cnt, input logic rr);
    checkOutput({tag, "_lookup_ready"}, 32'(lookup_ready_out), 32'(lr));
    checkOutput({tag, "_count"}, 32'(count_out), 32'(cnt));
    checkOutput({tag, "_res_ready"}, 32'(res_ready_out), 32'(rr));
  endtask

  // Monitor: compares every presented update and prediction against the scoreboard.
  always @(negedge clk_in) begin
    logic [32:0] e;
    logic        p;
    if (bp_update_valid_out === 1'b1) begin
      if (expUpd.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_update: got pc 0x%0h expected no update", bp_pc_out);
      end else begin
        e = expUpd.pop_front();
        checkOutput("update_pc", bp_pc_out, e[32:1]);
        checkOutput("update_taken", 32'(bp_correct_branch_out), 32'(e[0]));
      end
    end
    if (pred_valid_out === 1'b1) begin
      if (expPred.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pred: got pred_valid 1 expected 0");
      end else begin
        p = expPred.pop_front();
        checkOutput("pred_taken", 32'(pred_taken_out), 32'(p));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with every input active
    lookup_valid_in = 1'b1;
    lookup_pc_in    = 32'h10;
    res0_valid_in   = 1'b1;
    res0_pc_in      = 32'h500;
    res0_taken_in   = 1'b1;
    res1_valid_in   = 1'b1;
    res1_pc_in      = 32'h504;
    res1_taken_in   = 1'b1;
    bpForce         = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("rst_lookup_ready", 32'(lookup_ready_out), 32'(0));
    checkOutput("rst_pred_valid", 32'(pred_valid_out), 32'(0));
    checkOutput("rst_pred_taken", 32'(pred_taken_out), 32'(0));
    checkOutput("rst_res_ready", 32'(res_ready_out), 32'(0));
    checkOutput("rst_count", 32'(count_out), 32'(0));
    checkOutput("rst_bp_pc", bp_pc_out, 32'h0);
    checkOutput("rst_bp_update_valid", 32'(bp_update_valid_out), 32'(0));
    checkOutput("rst_bp_correct", 32'(bp_correct_branch_out), 32'(0));
    @(posedge clk_in);
    #1;
    bpForce  = 1'b0;
    rst_n_in = 1'b1;
    lookup_valid_in = 1'b0;
    res0_valid_in   = 1'b0;
    res1_valid_in   = 1'b0;
    @(negedge clk_in);
    checkCycle("post_rst", 1'b0, 0, 1'b1);

    // Lookup only
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      expPred.push_back(1'b1);
      checkOutput("lookup_ready", 32'(lookup_ready_out), 32'(1));
      checkOutput("lookup_pred_valid", 32'(pred_valid_out), 32'(i > 0));
    end
    idleCycle();
    checkOutput("lookup_last_pred_valid", 32'(pred_valid_out), 32'(1));
    idleCycle();
    checkOutput("lookup_pred_drop", 32'(pred_valid_out), 32'(0));

    // Dual enqueue ordering
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h104, 1'b0);
    expUpd.push_back({32'h100, 1'b1});
    expUpd.push_back({32'h104, 1'b0});
    checkCycle("dual_enq", 1'b0, 0, 1'b1);
    idleCycle();
    checkCycle("dual_first", 1'b0, 2, 1'b1);
    checkOutput("dual_first_upd", 32'(bp_update_valid_out), 32'(1));
    idleCycle();
    checkCycle("dual_second", 1'b0, 1, 1'b1);
    idleCycle();
    checkCycle("dual_empty", 1'b0, 0, 1'b1);
    checkOutput("dual_empty_upd", 32'(bp_update_valid_out), 32'(0));

    // Starvation guard
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
    expUpd.push_back({32'h200, 1'b1});
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      applyStimulus(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      expPred.push_back(1'b0);
      checkCycle("starve_wait", 1'b1, 1, 1'b1);
    end
    applyStimulus(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkCycle("starve_force", 1'b0, 1, 1'b1);
    checkOutput("starve_force_upd", 32'(bp_update_valid_out), 32'(1));
    applyStimulus(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    expPred.push_back(1'b0);
    checkCycle("starve_resume", 1'b1, 0, 1'b1);
    idleCycle();

    // Full FIFO and backpressure under continuous lookups
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h300, 1'b1, 1'b1, 32'h304, 1'b0);
    expUpd.push_back({32'h300, 1'b1});
    expUpd.push_back({32'h304, 1'b0});
    expPred.push_back(1'b1);
    checkCycle("full_c1", 1'b1, 0, 1'b1);
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h308, 1'b1, 1'b1, 32'h30C, 1'b1);
    expUpd.push_back({32'h308, 1'b1});
    expUpd.push_back({32'h30C, 1'b1});
    expPred.push_back(1'b1);
    checkCycle("full_c2", 1'b1, 2, 1'b1);
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h310, 1'b0, 1'b1, 32'h314, 1'b1);
    checkCycle("full_preempt", 1'b0, 4, 1'b0);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      applyStimulus(1'b1, 32'h10, 1'b1, 32'h310, 1'b0, 1'b1, 32'h314, 1'b1);
      expPred.push_back(1'b1);
      checkCycle("full_hold", 1'b1, 3, 1'b0);
    end
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h310, 1'b0, 1'b1, 32'h314, 1'b1);
    checkCycle("full_starve_upd", 1'b0, 3, 1'b0);
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h310, 1'b0, 1'b1, 32'h314, 1'b1);
    expUpd.push_back({32'h310, 1'b0});
    expUpd.push_back({32'h314, 1'b1});
    expPred.push_back(1'b1);
    checkCycle("full_accept", 1'b1, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idleCycle();
      checkCycle("full_drain", 1'b0, 4 - i, (4 - i) <= 2);
    end

    // Reset in the middle of a drain
    expUpd.push_back({32'h400, 1'b1});
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h400, 1'b1, 1'b1, 32'h404, 1'b0);
    expPred.push_back(1'b1);
    checkCycle("mid_a", 1'b1, 0, 1'b1);
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h408, 1'b1, 1'b0, 32'h0, 1'b0);
    expPred.push_back(1'b1);
    checkCycle("mid_b", 1'b1, 2, 1'b1);
    idleCycle();
    checkCycle("mid_c", 1'b0, 3, 1'b0);
    checkOutput("mid_c_upd", 32'(bp_update_valid_out), 32'(1));
    #2;
    rst_n_in = 1'b0;
    #1;
    checkOutput("mid_rst_upd", 32'(bp_update_valid_out), 32'(0));
    checkOutput("mid_rst_pc", bp_pc_out, 32'h0);
    checkOutput("mid_rst_count", 32'(count_out), 32'(0));
    checkOutput("mid_rst_res_ready", 32'(res_ready_out), 32'(0));
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    @(negedge clk_in);
    checkCycle("mid_release", 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("mid_no_stale", 32'(bp_update_valid_out), 32'(0));
    end

    checkOutput("upd_queue_drained", 32'(expUpd.size()), 32'(0));
    checkOutput("pred_queue_drained", 32'(expPred.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
